// File: rtl/multi_period_ctrl_pkg.sv
// Shared constants for the multi-period CPU control path: opcodes, functs,
// state encodings and ALU control codes.
package multi_period_ctrl_pkg;

   localparam int STATE_W_DEF = 4;
   localparam int ALUC_W_DEF  = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_SUB = 4'b0110;
   localparam logic [3:0] ALUC_SLT = 4'b0111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   function automatic logic op_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_supported = 1'b1;
         default:                                        op_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multi_period_ctrl_if.sv
// Control bus between the multi-period controller (master) and the datapath
// (slave): decoded instruction fields in, enables and mux selects out.
interface multi_period_ctrl_if #(
   parameter int STATE_W = 4,
   parameter int ALUC_W  = 4
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               pc_en;
   logic               iord;
   logic               mem_rd;
   logic               mem_wr;
   logic               ir_wr;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_wr;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUC_W-1:0]  alu_ctrl;
   logic [1:0]         pc_src;
   logic [STATE_W-1:0] state;
   logic               instr_done;
   logic               illegal;

   modport master (
      input  opcode, funct, zero,
      output pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
             alu_src_a, alu_src_b, alu_ctrl, pc_src, state, instr_done, illegal
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
             alu_src_a, alu_src_b, alu_ctrl, pc_src, state, instr_done, illegal
   );
endinterface

// File: rtl/multi_period_alu_ctrl.sv
// ALU control decode: the FSM picks add, sub or funct-driven operation and
// this block turns that into the ALU's operation code.
module multi_period_alu_ctrl
   import multi_period_ctrl_pkg::*;
#(
   parameter int ALUC_W = 4
) (
   input  alu_op_e           alu_op,
   input  logic [5:0]        funct,
   output logic [ALUC_W-1:0] alu_ctrl
);

   logic [3:0] funct_code;

   always_comb begin
      funct_code = ALUC_ADD;
      case (funct)
         FN_ADD:  funct_code = ALUC_ADD;
         FN_SUB:  funct_code = ALUC_SUB;
         FN_AND:  funct_code = ALUC_AND;
         FN_OR:   funct_code = ALUC_OR;
         FN_SLT:  funct_code = ALUC_SLT;
         default: funct_code = ALUC_ADD;
      endcase
   end

   // Unknown funct values fall back to add rather than flagging an error.
   always_comb begin
      alu_ctrl = ALUC_W'(ALUC_ADD);
      case (alu_op)
         ALUOP_ADD:   alu_ctrl = ALUC_W'(ALUC_ADD);
         ALUOP_SUB:   alu_ctrl = ALUC_W'(ALUC_SUB);
         ALUOP_FUNCT: alu_ctrl = ALUC_W'(funct_code);
         default:     alu_ctrl = ALUC_W'(ALUC_ADD);
      endcase
   end

endmodule

// File: rtl/multi_period_ctrl.sv
// Moore control FSM for the multi-period CPU: sequences each instruction
// through fetch, decode, execute, memory and writeback.
module multi_period_ctrl
   import multi_period_ctrl_pkg::*;
#(
   parameter int STATE_W = STATE_W_DEF,
   parameter int ALUC_W  = ALUC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   multi_period_ctrl_if.master  bus
);

   state_e            state_q;
   state_e            state_d;
   alu_op_e           alu_op;
   logic [ALUC_W-1:0] alu_ctrl;

   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_rd;
   logic       mem_wr;
   logic       ir_wr;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_wr;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       instr_done;
   logic       illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = S_FETCH;
      alu_op        = ALUOP_ADD;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      ir_wr         = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_wr        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      instr_done    = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         S_FETCH: begin
            state_d   = S_DECODE;
            mem_rd    = 1'b1;
            ir_wr     = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
         end

         // Branch target is computed speculatively here and parked in ALUOut.
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end

         S_MEM_ADDR: begin
            state_d   = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end

         S_MEM_RD: begin
            state_d = S_MEM_WB;
            mem_rd  = 1'b1;
            iord    = 1'b1;
         end

         S_MEM_WB: begin
            reg_wr     = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end

         S_MEM_WR: begin
            mem_wr     = 1'b1;
            iord       = 1'b1;
            instr_done = 1'b1;
         end

         S_EXEC: begin
            state_d   = S_R_WB;
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end

         S_R_WB: begin
            reg_wr     = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end

         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_src        = 2'b01;
            pc_write_cond = 1'b1;
            instr_done    = 1'b1;
         end

         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end

         S_ADDI_EX: begin
            state_d   = S_ADDI_WB;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end

         S_ADDI_WB: begin
            reg_wr     = 1'b1;
            instr_done = 1'b1;
         end

         default: state_d = S_FETCH;
      endcase
   end

   multi_period_alu_ctrl #(
      .ALUC_W (ALUC_W)
   ) u_alu_ctrl (
      .alu_op   (alu_op),
      .funct    (bus.funct),
      .alu_ctrl (alu_ctrl)
   );

   // Architectural writes are suppressed while reset is held so an aborted
   // instruction leaves no trace.
   assign bus.pc_en      = ~rst & (pc_write | (pc_write_cond & bus.zero));
   assign bus.mem_wr     = ~rst & mem_wr;
   assign bus.ir_wr      = ~rst & ir_wr;
   assign bus.reg_wr     = ~rst & reg_wr;

   assign bus.iord       = iord;
   assign bus.mem_rd     = mem_rd;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_ctrl   = alu_ctrl;
   assign bus.pc_src     = pc_src;
   assign bus.state      = STATE_W'(state_q);
   assign bus.instr_done = instr_done;
   assign bus.illegal    = illegal;

endmodule

// File: doc/multi_period_ctrl.md
Name: multi_period_ctrl

Overview:
Control FSM that sequences the multi-period CPU datapath: PC, unified instruction/data memory, IR, register file and ALU. It walks each instruction through FETCH/DECODE/execute/memory/writeback states and drives every datapath enable and mux select. It sits inside multi_period_cpu beside the datapath, driven by the CPU clock and reset. It decodes a MIPS subset: R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

Parameters:
STATE_W, 4, state register width
ALUC_W, 4, width of the ALU control code to the ALU

Ports:
clk  in  1  CPU clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational from current ALU operands
pc_en  out  1  PC register write enable (pc_write OR (pc_write_cond AND zero))
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_rd  out  1  memory read
mem_wr  out  1  memory write
ir_wr  out  1  IR load enable
reg_dst  out  1  write-register select: 0=rt, 1=rd
mem_to_reg  out  1  write-data select: 0=ALUOut, 1=MDR
reg_wr  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_ctrl  out  ALUC_W  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],IR[25:0],2'b00}
state  out  STATE_W  current state, debug
instr_done  out  1  high in the last state of each instruction
illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- State register is updated on the rising edge of clk. rst=1 at an edge loads FETCH(0). Reset mid-instruction aborts it: no partial writes after that edge.
- Outputs are decoded combinationally from state only (Moore). The exceptions are pc_en, which uses zero, and alu_ctrl and illegal, which use opcode/funct. While rst=1, pc_en, mem_wr, ir_wr and reg_wr are forced to 0.
- Signals not listed for a state are 0. Selects not listed for a state are don't-care and are driven 0.
- State list (encoding / next state / asserted outputs):
- FETCH 0 / DECODE / mem_rd, ir_wr, iord=0, alu_src_a=0, alu_src_b=01, ALU add, pc_src=00, pc_en=1.
- DECODE 1 / by opcode: lw or sw -> MEM_ADDR, R -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EX, other -> FETCH with illegal=1. Outputs: alu_src_a=0, alu_src_b=11, ALU add (branch target into ALUOut).
- MEM_ADDR 2 / lw -> MEM_RD, sw -> MEM_WR / alu_src_a=1, alu_src_b=10, ALU add.
- MEM_RD 3 / MEM_WB / mem_rd, iord=1.
- MEM_WB 4 / FETCH / reg_wr, reg_dst=0, mem_to_reg=1, instr_done.
- MEM_WR 5 / FETCH / mem_wr, iord=1, instr_done.
- EXEC 6 / R_WB / alu_src_a=1, alu_src_b=00, alu_ctrl from funct.
- R_WB 7 / FETCH / reg_wr, reg_dst=1, mem_to_reg=0, instr_done.
- BRANCH 8 / FETCH / alu_src_a=1, alu_src_b=00, ALU sub, pc_src=01, pc_en=zero, instr_done.
- JUMP 9 / FETCH / pc_src=10, pc_en=1, instr_done.
- ADDI_EX 10 / ADDI_WB / alu_src_a=1, alu_src_b=10, ALU add.
- ADDI_WB 11 / FETCH / reg_wr, reg_dst=0, mem_to_reg=0, instr_done.
- Codes 12-15 are unreachable. If entered, the next state is FETCH.
- Latency per instruction: lw 5 cycles; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
- An R-type instruction with an unknown funct executes as add. It does not raise illegal.
- ALU control decode:
  - alu_op add yields 0010 regardless of funct.
  - alu_op sub yields 0110.
  - alu_op funct maps: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, anything else -> 0010.

Decomposition:
- Shared defines header (the existing defines.v) holds:
  - opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_ADDI 001000;
  - funct constants;
  - the 4-bit state encodings;
  - the ALU control codes.
- One sub-module, multi_period_alu_ctrl: combinational, alu_op[1:0] (00 add, 01 sub, 10 funct) plus funct in, alu_ctrl out. The FSM drives alu_op per state.

Test Plan:
- Hold rst=1 for 2 cycles with opcode=100011 -> state=0; pc_en, reg_wr, mem_wr and ir_wr all 0. First cycle after release: state=0, mem_rd=1, ir_wr=1, pc_en=1.
- lw (opcode 100011) -> state sequence 0,1,2,3,4,0. In state 3 iord=1 and mem_rd=1. In state 4 reg_wr=1, mem_to_reg=1, instr_done=1.
- R-type sub (funct 100010) -> sequence 0,1,6,7,0. In state 6 alu_ctrl=0110. In state 7 reg_dst=1 and reg_wr=1. Repeat with slt (101010) -> alu_ctrl=0111.
- beq in state 8: zero=1 -> pc_en=1, pc_src=01. zero=0 -> pc_en=0. Both cases return to state 0 after 3 cycles.
- j -> sequence 0,1,9,0 with pc_src=10 and pc_en=1 in state 9. sw -> 0,1,2,5,0 with mem_wr=1 only in state 5.
- Opcode 111111 -> illegal=1 for exactly one cycle in state 1, then state 0. Separately, assert rst while in state 3 -> next state 0 and no reg_wr pulse.
